// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// state encodings, opcodes, alu_op codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // alu_op codes, also decoded by the ALU control block
  localparam logic [2:0] ALU_LUI   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b011;
  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH  = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;
  localparam logic [1:0] DST_RT       = 2'b00;
  localparam logic [1:0] DST_RD       = 2'b01;
  localparam logic [1:0] DST_R31      = 2'b10;
  localparam logic [1:0] M2R_ALUOUT   = 2'b00;
  localparam logic [1:0] M2R_MDR      = 2'b01;
  localparam logic [1:0] M2R_PC       = 2'b10;

  // DECODE dispatch target; unknown opcodes fall back to FETCH
  function automatic state_t dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:                         return S_EXEC_R;
      OP_LW, OP_SW:                     return S_MEM_ADDR;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: return S_EXEC_I;
      OP_BEQ, OP_BNE:                   return S_BRANCH;
      OP_J:                             return S_JUMP;
      OP_JAL:                           return S_JAL;
      default:                          return S_FETCH;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) ||
           (op == OP_LUI) || (op == OP_BEQ) || (op == OP_BNE) ||
           (op == OP_J) || (op == OP_JAL);
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      OP_LUI:  return ALU_LUI;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter with timeout compare. Counts cycles spent in a
// memory-wait state without mem_ready; o_expired flags the last allowed cycle.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_restart,
  input  logic i_ready,
  output logic o_expired
);

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] LAST = TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] r_cnt;

  // clear on entry to a wait state, count idle cycles while waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_active && !i_ready && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_expired = i_active && !i_ready && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM (fetch/decode/execute/memory/writeback).
// Optional build macro RETIRE_COUNT_EN adds retired_o, a count of
// instructions that completed (illegal and timeout aborts excluded).
//
// state      | meaning
// FETCH    0 | read instruction at PC, PC+4 on mem_ready
// DECODE   1 | latch opcode, branch target into ALUOut, dispatch
// EXEC_R   2 | R-type ALU op, or jr redirect
// WB_R     3 | write rd from ALUOut
// EXEC_I   4 | immediate ALU op
// WB_I     5 | write rt from ALUOut
// MEM_ADDR 6 | effective address for lw/sw
// MEM_RD   7 | data read, wait for mem_ready
// WB_MEM   8 | write rt from MDR
// MEM_WR   9 | data write, wait for mem_ready
// BRANCH  10 | compare, conditional PC load from ALUOut
// JUMP    11 | PC <- jump target
// JAL     12 | PC <- jump target, r31 <- PC
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       jr_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [2:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] reg_dst_o,
  output logic [1:0] mem_to_reg_o,
  output logic       illegal_o,
  output logic       mem_timeout_o,
  output logic [3:0] state_o
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] retired_o
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_op;
  logic       r_illegal;
  logic       r_timeout;
  logic       w_illegal_set;
  logic       w_tmo_set;
  logic       w_expired;
  logic       w_waiting;
  logic       w_restart;

  assign w_waiting = r_state inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  // a timeout re-entering FETCH counts as a fresh entry
  assign w_restart = (w_next inside {S_FETCH, S_MEM_RD, S_MEM_WR}) &&
                     ((w_next != r_state) || w_tmo_set);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk       (clk),
    .reset     (reset),
    .i_active  (w_waiting),
    .i_restart (w_restart),
    .i_ready   (mem_ready_i),
    .o_expired (w_expired)
  );

  // next-state selection; mem_ready wins over an expiring wait
  always_comb begin
    w_next        = S_FETCH;
    w_illegal_set = 1'b0;
    w_tmo_set     = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready_i)    w_next = S_DECODE;
        else if (w_expired) w_tmo_set = 1'b1;
        else                w_next = S_FETCH;
      end
      S_DECODE: begin
        w_next        = dispatch(opcode_i);
        w_illegal_set = !op_legal(opcode_i);
      end
      S_EXEC_R:   w_next = jr_i ? S_FETCH : S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready_i)    w_next = S_WB_MEM;
        else if (w_expired) w_tmo_set = 1'b1;
        else                w_next = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (mem_ready_i)    w_next = S_FETCH;
        else if (w_expired) w_tmo_set = 1'b1;
        else                w_next = S_MEM_WR;
      end
      default:    w_next = S_FETCH;
    endcase
  end

  // state register, opcode latch and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_op      <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= opcode_i;
      if (w_illegal_set)       r_illegal <= 1'b1;
      if (w_tmo_set)           r_timeout <= 1'b1;
    end
  end

  // Moore decode of datapath controls; FETCH/EXEC_R/BRANCH PC loads qualify on inputs
  always_comb begin
    alu_op_o     = ALU_LUI;
    alu_src_a_o  = SRCA_PC;
    alu_src_b_o  = SRCB_REG;
    pc_source_o  = PCSRC_ALU;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = DST_RT;
    mem_to_reg_o = M2R_ALUOUT;
    case (r_state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_op_o    = ALU_ADD;
        // reset holds FETCH, so the load strobes are gated by the reset pin
        pc_write_o  = mem_ready_i & reset;
        ir_write_o  = mem_ready_i & reset;
      end
      S_DECODE: begin
        alu_src_b_o = SRCB_IMM_SH;
        alu_op_o    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a_o = SRCA_REG;
        alu_op_o    = ALU_RTYPE;
        pc_write_o  = jr_i;
        pc_source_o = jr_i ? PCSRC_REGA : PCSRC_ALU;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = DST_RD;
      end
      S_EXEC_I: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = imm_alu_op(r_op);
      end
      S_WB_I: reg_write_o = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a_o = SRCA_REG;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o = SRCA_REG;
        alu_op_o    = ALU_SUB;
        pc_source_o = PCSRC_ALUOUT;
        pc_write_o  = ((r_op == OP_BEQ) && zero_i) || ((r_op == OP_BNE) && !zero_i);
      end
      S_JUMP: begin
        pc_write_o  = 1'b1;
        pc_source_o = PCSRC_JUMP;
      end
      S_JAL: begin
        pc_write_o   = 1'b1;
        pc_source_o  = PCSRC_JUMP;
        reg_write_o  = 1'b1;
        reg_dst_o    = DST_R31;
        mem_to_reg_o = M2R_PC;
      end
      default: ;
    endcase
  end

  assign illegal_o     = r_illegal;
  assign mem_timeout_o = r_timeout;
  assign state_o       = r_state;

`ifdef RETIRE_COUNT_EN
  logic [31:0] r_retired;
  logic        w_retire;

  assign w_retire = (w_next == S_FETCH) && !w_tmo_set &&
                    (r_state inside {S_EXEC_R, S_WB_R, S_WB_I, S_WB_MEM,
                                     S_MEM_WR, S_BRANCH, S_JUMP, S_JAL});

  // count instructions that run to completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign retired_o = r_retired;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode_i;
  logic        jr_i, zero_i, mem_ready_i;
  logic [2:0]  alu_op_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o, pc_source_o;
  logic        pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o, reg_write_o;
  logic [1:0]  reg_dst_o, mem_to_reg_o;
  logic        illegal_o, mem_timeout_o;
  logic [3:0]  state_o;
`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_o;
`endif

  int          checks = 0;
  int          failures = 0;
  logic        exp_ill, exp_tmo;
  logic [31:0] exp_ret;
  logic [5:0]  cur_op;
  logic [17:0] dut_outs;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk           (clk),
    .reset         (reset),
    .opcode_i      (opcode_i),
    .jr_i          (jr_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .alu_op_o      (alu_op_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .pc_source_o   (pc_source_o),
    .pc_write_o    (pc_write_o),
    .ir_write_o    (ir_write_o),
    .i_or_d_o      (i_or_d_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .reg_write_o   (reg_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .illegal_o     (illegal_o),
    .mem_timeout_o (mem_timeout_o),
    .state_o       (state_o)
`ifdef RETIRE_COUNT_EN
    ,
    .retired_o     (retired_o)
`endif
  );

  assign dut_outs = {alu_op_o, alu_src_a_o, alu_src_b_o, pc_source_o, pc_write_o, ir_write_o,
                     i_or_d_o, mem_read_o, mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o};

  // Control table: what each state must drive, straight from the state descriptions
  function automatic logic [17:0] exp_outs(input int st, input logic rdy, input logic jr,
                                           input logic zero, input logic [5:0] op);
    logic [2:0] alu = 3'b000;
    logic       sa = 1'b0;
    logic [1:0] sb = 2'b00, ps = 2'b00, rd = 2'b00, m2r = 2'b00;
    logic       pw = 1'b0, iw = 1'b0, iod = 1'b0, mr = 1'b0, mw = 1'b0, rw = 1'b0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; alu = 3'b100; pw = rdy; iw = rdy; end
      1:  begin sb = 2'b11; alu = 3'b100; end
      2:  begin sa = 1; alu = 3'b111; pw = jr; ps = jr ? 2'b11 : 2'b00; end
      3:  begin rw = 1; rd = 2'b01; end
      4:  begin
            sa = 1; sb = 2'b10;
            alu = (op == 6'h0C) ? 3'b010 : (op == 6'h0D) ? 3'b001 : (op == 6'h0F) ? 3'b000 : 3'b100;
          end
      5:  rw = 1;
      6:  begin sa = 1; sb = 2'b10; alu = 3'b100; end
      7:  begin mr = 1; iod = 1; end
      8:  begin rw = 1; m2r = 2'b01; end
      9:  begin mw = 1; iod = 1; end
      10: begin sa = 1; alu = 3'b011; ps = 2'b01; pw = (op == 6'h04) ? zero : !zero; end
      11: begin pw = 1; ps = 2'b10; end
      12: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    return {alu, sa, sb, ps, pw, iw, iod, mr, mw, rw, rd, m2r};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: drive mem_ready at the falling edge, compare, advance to next falling edge
  task automatic cycle(input int st, input logic rdy);
    logic [17:0] e;
    mem_ready_i = rdy;
    #1;
    checks++;
    if (state_o !== 4'(st)) begin
      failures++;
      $display("FAIL state: got=%0d exp=%0d t=%0t", state_o, st, $time);
    end
    e = exp_outs(st, rdy, jr_i, zero_i, cur_op);
    checks++;
    if (dut_outs !== e) begin
      failures++;
      $display("FAIL outputs st=%0d op=%h: got=%h exp=%h t=%0t", st, cur_op, dut_outs, e, $time);
    end
    checks++;
    if ({illegal_o, mem_timeout_o} !== {exp_ill, exp_tmo}) begin
      failures++;
      $display("FAIL flags ill/tmo: got=%b%b exp=%b%b t=%0t", illegal_o, mem_timeout_o,
               exp_ill, exp_tmo, $time);
    end
`ifdef RETIRE_COUNT_EN
    checks++;
    if (retired_o !== exp_ret) begin
      failures++;
      $display("FAIL retired: got=%0d exp=%0d t=%0t", retired_o, exp_ret, $time);
    end
`endif
    @(negedge clk);
  endtask

  // Memory wait of dly idle cycles in state st; returns 1 if the access completed
  task automatic mem_wait(input int st, input int dly, output logic done);
    if (dly >= TMO) begin
      repeat (TMO) cycle(st, 1'b0);
      exp_tmo = 1'b1;
      done = 1'b0;
    end else begin
      repeat (dly) cycle(st, 1'b0);
      cycle(st, 1'b1);
      done = 1'b1;
    end
  endtask

  // One whole instruction, with expected state walk derived from its opcode
  task automatic run_instr(input logic [5:0] op, input logic jr, input logic zero,
                           input int fdly, input int mdly);
    int   rem;
    logic done;
    jr_i = jr; zero_i = zero; cur_op = op;
    rem = fdly;
    while (rem >= TMO) begin
      for (int i = 0; i < TMO; i++) begin opcode_i = 6'($urandom); cycle(0, 1'b0); end
      exp_tmo = 1'b1;
      rem -= TMO;
    end
    for (int i = 0; i < rem; i++) begin opcode_i = 6'($urandom); cycle(0, 1'b0); end
    opcode_i = 6'($urandom);
    cycle(0, 1'b1);
    opcode_i = op;
    cycle(1, rb());
    opcode_i = 6'($urandom);
    case (op)
      6'h00: begin
        cycle(2, rb());
        if (!jr) cycle(3, rb());
        exp_ret = exp_ret + 1;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin
        cycle(4, rb()); cycle(5, rb());
        exp_ret = exp_ret + 1;
      end
      6'h23: begin
        cycle(6, rb());
        mem_wait(7, mdly, done);
        if (done) begin cycle(8, rb()); exp_ret = exp_ret + 1; end
      end
      6'h2B: begin
        cycle(6, rb());
        mem_wait(9, mdly, done);
        if (done) exp_ret = exp_ret + 1;
      end
      6'h04, 6'h05: begin cycle(10, rb()); exp_ret = exp_ret + 1; end
      6'h02:        begin cycle(11, rb()); exp_ret = exp_ret + 1; end
      6'h03:        begin cycle(12, rb()); exp_ret = exp_ret + 1; end
      default:      exp_ill = 1'b1;
    endcase
  endtask

  // Async reset from the middle of operation: state and sticky flags clear at once
  task automatic do_reset;
    reset = 1'b0;
    #1;
    checks++;
    if ({state_o, illegal_o, mem_timeout_o} !== 6'b0) begin
      failures++;
      $display("FAIL async_reset: got state=%0d ill=%b tmo=%b exp 0/0/0", state_o, illegal_o,
               mem_timeout_o);
    end
`ifdef RETIRE_COUNT_EN
    checks++;
    if (retired_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_retired: got=%0d exp=0", retired_o);
    end
`endif
    exp_ill = 1'b0; exp_tmo = 1'b0; exp_ret = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_ready_i = 1'b1; opcode_i = '0; jr_i = 1'b0; zero_i = 1'b0;
    exp_ill = 1'b0; exp_tmo = 1'b0; exp_ret = '0; cur_op = '0;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if ({pc_write_o, ir_write_o} !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes: got pc_write=%b ir_write=%b exp 0 0", pc_write_o, ir_write_o);
    end
    checks++;
    if (dut_outs !== exp_outs(0, 1'b0, 1'b0, 1'b0, 6'h00) || state_o !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: got st=%0d outs=%h exp st=0 outs=%h", state_o, dut_outs,
               exp_outs(0, 1'b0, 1'b0, 1'b0, 6'h00));
    end
    checks++;
    if ({illegal_o, mem_timeout_o} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got %b%b exp 00", illegal_o, mem_timeout_o);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_rtype;
    run_instr(6'h00, 1'b0, rb(), 0, 0);
    run_instr(6'h00, 1'b1, rb(), 1, 0);
  endtask

  task automatic test_mem;
    run_instr(6'h23, 1'b0, rb(), 0, 3);
    run_instr(6'h2B, 1'b0, rb(), 2, 2);
    run_instr(6'h23, 1'b0, rb(), 0, 0);
  endtask

  task automatic test_branch;
    run_instr(6'h04, 1'b0, 1'b1, 0, 0);
    run_instr(6'h05, 1'b0, 1'b1, 0, 0);
    run_instr(6'h04, 1'b0, 1'b0, 0, 0);
    run_instr(6'h05, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_itype_jump;
    run_instr(6'h08, 1'b0, rb(), 0, 0);
    run_instr(6'h0C, 1'b0, rb(), 0, 0);
    run_instr(6'h0D, 1'b0, rb(), 0, 0);
    run_instr(6'h0F, 1'b0, rb(), 0, 0);
    run_instr(6'h02, 1'b0, rb(), 0, 0);
    run_instr(6'h03, 1'b0, rb(), 0, 0);
  endtask

  task automatic test_timeouts;
    run_instr(6'h0D, 1'b0, 1'b0, 15, 0);   // ready on the last allowed cycle
    run_instr(6'h08, 1'b0, 1'b0, 16, 0);   // fetch abort then retry
    do_reset;
    run_instr(6'h2B, 1'b0, 1'b0, 0, 15);
    run_instr(6'h23, 1'b0, 1'b0, 0, 16);
    run_instr(6'h0D, 1'b0, 1'b0, 0, 0);
    do_reset;
    run_instr(6'h2B, 1'b0, 1'b0, 0, 17);
    run_instr(6'h23, 1'b0, 1'b0, 0, 15);
  endtask

  task automatic test_illegal;
    do_reset;
    run_instr(6'h3F, 1'b0, 1'b0, 0, 0);
    run_instr(6'h0D, 1'b0, 1'b0, 0, 0);
    run_instr(6'h11, 1'b0, 1'b0, 1, 0);
  endtask

  task automatic test_random;
    logic [5:0] legal [11];
    logic [5:0] op;
    int         fd, md;
    legal = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    do_reset;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else                           op = legal[$urandom_range(0, 10)];
      fd = ($urandom_range(0, 11) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
      md = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
      run_instr(op, rb(), rb(), fd, md);
    end
  endtask

  initial begin
    test_reset;
    test_rtype;
    test_mem;
    test_branch;
    test_itype_jump;
    test_timeouts;
    test_illegal;
    test_random;
    do_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle MIPS main control FSM.
- Sequences fetch, decode, execute, memory and writeback.
- Drives the 3-bit alu_op code consumed by the ALU control decoder, plus all datapath/memory enables.
- Consumes the decoder's jr flag and the ALU zero flag.
- Sits between the instruction register and the datapath muxes/register file/memory port.

Parameters:
MEM_TIMEOUT, 16, max cycles any memory state waits for mem_ready_i before aborting.
TMO_W, $clog2(MEM_TIMEOUT), wait-counter width (derived).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode_i  input  6  instruction opcode from IR
jr_i  input  1  jr detect from ALU control
zero_i  input  1  ALU zero flag
mem_ready_i  input  1  memory completes current read/write this cycle
alu_op_o  output  3  ALU control code: 111 R, 100 add, 010 and, 001 or, 000 lui, 011 sub
alu_src_a_o  output  1  0=PC, 1=reg A
alu_src_b_o  output  2  00=reg B, 01=4, 10=sign-ext imm, 11=imm<<2
pc_source_o  output  2  00=ALU, 01=ALUOut, 10=jump target, 11=reg A
pc_write_o  output  1  PC load
ir_write_o  output  1  IR load
i_or_d_o  output  1  mem address 0=PC, 1=ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
reg_write_o  output  1  register file write
reg_dst_o  output  2  00=rt, 01=rd, 10=r31
mem_to_reg_o  output  2  00=ALUOut, 01=MDR, 10=PC
illegal_o  output  1  sticky: unknown opcode decoded
mem_timeout_o  output  1  sticky: memory wait exceeded MEM_TIMEOUT
state_o  output  4  current state encoding (debug)

Behaviour:
- Moore FSM. All outputs are decoded from state, except:
  - FETCH pc_write_o/ir_write_o = mem_ready_i.
  - BRANCH pc_write_o.
- Unlisted outputs are 0 in every state.
- opcode_i is registered into op_q in DECODE. Later states use op_q only.
- Reset low:
  - state=FETCH(0), op_q=0, wait counter=0, illegal_o=0, mem_timeout_o=0.
  - pc_write_o, ir_write_o, reg_write_o, mem_write_o forced 0.
  - FETCH values otherwise: mem_read_o=1, alu_op_o=100, alu_src_b_o=01; all other outputs 0.
- States and transitions:
  - FETCH(0): mem_read, i_or_d=0, src_a=0, src_b=01, alu_op=100, pc_source=00. Hold until mem_ready_i, then DECODE.
  - DECODE(1): src_a=0, src_b=11, alu_op=100 (branch target into ALUOut). Dispatch on opcode_i:
    - 0x00 -> EXEC_R
    - 0x23/0x2B -> MEM_ADDR
    - 0x08/0x0C/0x0D/0x0F -> EXEC_I
    - 0x04/0x05 -> BRANCH
    - 0x02 -> JUMP
    - 0x03 -> JAL
    - other -> set illegal_o, go to FETCH
  - EXEC_R(2): src_a=1, src_b=00, alu_op=111.
    - If jr_i: pc_write=1, pc_source=11, go to FETCH (no writeback).
    - Else go to WB_R.
  - WB_R(3): reg_write, reg_dst=01, mem_to_reg=00. Go to FETCH.
  - EXEC_I(4): src_a=1, src_b=10. alu_op: addi 100, andi 010, ori 001, lui 000. Go to WB_I.
  - WB_I(5): reg_write, reg_dst=00. Go to FETCH.
  - MEM_ADDR(6): src_a=1, src_b=10, alu_op=100. lw goes to MEM_RD, sw goes to MEM_WR.
  - MEM_RD(7): mem_read, i_or_d=1. On mem_ready_i go to WB_MEM.
  - WB_MEM(8): reg_write, reg_dst=00, mem_to_reg=01. Go to FETCH.
  - MEM_WR(9): mem_write, i_or_d=1. On mem_ready_i go to FETCH.
  - BRANCH(10): src_a=1, src_b=00, alu_op=011, pc_source=01.
    - pc_write = (beq & zero_i) | (bne & ~zero_i).
    - Go to FETCH.
  - JUMP(11): pc_write, pc_source=10. Go to FETCH.
  - JAL(12): pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10. Go to FETCH.
  - Encodings 13-15: go to FETCH next cycle, all outputs 0.
- Wait counter:
  - Clears on entry to FETCH/MEM_RD/MEM_WR.
  - Increments each cycle in those states while mem_ready_i=0.
  - Reaching MEM_TIMEOUT-1 with mem_ready_i still 0 sets mem_timeout_o and aborts:
    - FETCH re-enters FETCH (counter cleared).
    - MEM_RD/MEM_WR go to FETCH without writeback.
- mem_ready_i on the timeout cycle takes priority: the access completes normally.
- Sticky flags clear only on reset.

Optional Feature:
RETIRE_COUNT_EN
- Defined: adds port retired_o (output, 32).
  - Resets to 0.
  - Increments by 1 on every transition into FETCH from a completed instruction.
  - Illegal-opcode and timeout aborts do not count.
  - Wraps 0xFFFFFFFF -> 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - alu_op code constants, shared with the ALU control decoder
  - mux-select encodings
- One sub-module, mem_wait_timer: wait counter plus timeout compare, parameterised by MEM_TIMEOUT.

Test Plan:
1. Reset low with mem_ready_i=1 -> pc_write_o=0, state_o=0, mem_read_o=1. Release -> pc_write_o=1, ir_write_o=1; DECODE next cycle.
2. add (opcode 0x00, jr_i=0) -> states 0,1,2,3; alu_op_o=111 in EXEC_R; reg_write_o=1, reg_dst_o=01 in WB_R. jr_i=1 variant: pc_source_o=11, pc_write_o=1, no WB_R.
3. lw with mem_ready_i delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with mem_to_reg_o=01. sw -> MEM_WR, mem_write_o=1, no reg_write.
4. beq with zero_i=1 -> pc_write_o=1, alu_op_o=011, pc_source_o=01. bne with zero_i=1 -> pc_write_o=0.
5. mem_ready_i held 0 in FETCH, MEM_TIMEOUT=16 -> mem_timeout_o rises after 16 cycles; FETCH re-entered and retry succeeds.
6. opcode 0x3F -> illegal_o=1, FETCH next cycle. Under RETIRE_COUNT_EN, retired_o is unchanged; after ori it increments by 1.
